pc_unit: RTL and testbench

Parametrised program-counter unit for the IF stage of the MIPS pipeline. It holds the fetch address and selects the next one from sequential increment, EX-stage branch/jump redirect, or exception vector. It adds stall, halt/resume and debug single-step control. It provides a fetch-valid qualifier, a misalignment flag and a saturating fetch counter for the debug unit.

---
 rtl/pc_unit.sv | 67 ++++++
 tb/tb_pc_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with redirect, exception, halt/resume and debug single-step control.
module pc_unit #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_W-1:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int                INC          = 4,
  parameter int                CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [DATA_W-1:0] i_redirect_pc,
  input  logic              i_exception,
  input  logic              i_halt,
  input  logic              i_resume,
  input  logic              i_step_mode,
  input  logic              i_step,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_pc_next_seq,
  output logic              o_fetch_valid,
  output logic [1:0]        o_state,
  output logic [CNT_W-1:0]  o_fetch_count,
  output logic              o_misaligned
);
  typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, STEP_WAIT = 2'd2} state_t;
  state_t state, state_nx;
  logic primed, active, take_exc, take_redir, take_halt, take_seq, adv, cnt_inc;
  assign active     = state != HALTED;
  assign take_exc   = active & i_exception;
  assign take_redir = active & i_redirect & ~i_exception;
  // a redirect or exception in the same cycle marks the HALT as wrong-path
  assign take_halt  = active & i_halt & ~i_redirect & ~i_exception;
  // the first edge out of reset only primes fetch; sequential advance starts on the next
  assign take_seq   = active & ~i_exception & ~i_redirect & ~i_halt & ~i_stall &
                      (state == RUN ? primed : i_step);
  assign adv        = take_exc | take_redir | take_seq;
  assign cnt_inc    = adv & (o_fetch_count != '1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= RUN;
    else         state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = take_halt                        ? HALTED    :
               (state == RUN && i_step_mode)     ? STEP_WAIT :
               (state == STEP_WAIT && !i_step_mode) ? RUN    :
               (state == HALTED && i_resume)     ? (i_step_mode ? STEP_WAIT : RUN) :
               state;
  end
  always_comb begin
    o_state       = state;
    o_pc_next_seq = o_pc + DATA_W'(INC);
    o_misaligned  = o_pc[1:0] != 2'b00;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_pc          <= RESET_VECTOR;
      o_fetch_valid <= 1'b0;
      o_fetch_count <= '0;
      primed        <= 1'b0;
    end else begin
      o_pc          <= take_exc ? EXC_VECTOR : take_redir ? i_redirect_pc : take_seq ? o_pc_next_seq : o_pc;
      o_fetch_valid <= !take_halt && (state == RUN || (state == STEP_WAIT && adv));
      o_fetch_count <= o_fetch_count + CNT_W'(cnt_inc);
      primed        <= 1'b1;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed table plus randomized run against a behavioural model, two parameterisations.
module tb_pc_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        stall = 0, redir = 0, exc = 0, halt = 0, resume = 0, sm = 0, step = 0;
  logic [31:0] rpc = '0;
  logic [31:0] pc_a, nxt_a, cnt_a, pc_b, nxt_b;
  logic        fv_a, mis_a, fv_b, mis_b;
  logic [1:0]  st_a, st_b, cnt_b;
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  pc_unit dut_a (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_redirect(redir), .i_redirect_pc(rpc),
    .i_exception(exc), .i_halt(halt), .i_resume(resume), .i_step_mode(sm), .i_step(step),
    .o_pc(pc_a), .o_pc_next_seq(nxt_a), .o_fetch_valid(fv_a), .o_state(st_a),
    .o_fetch_count(cnt_a), .o_misaligned(mis_a));

  pc_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_redirect(redir), .i_redirect_pc(rpc),
    .i_exception(exc), .i_halt(halt), .i_resume(resume), .i_step_mode(sm), .i_step(step),
    .o_pc(pc_b), .o_pc_next_seq(nxt_b), .o_fetch_valid(fv_b), .o_state(st_b),
    .o_fetch_count(cnt_b), .o_misaligned(mis_b));

  typedef struct {
    logic stall, redir; logic [31:0] rpc; logic exc, halt, resume, sm, step;
  } vec_t;
  typedef struct {
    vec_t in; logic [31:0] pc; logic [1:0] st; logic fv; logic [31:0] cnt;
  } row_t;
  row_t tbl[$];

  function automatic vec_t v(logic s, logic r, logic [31:0] p, logic e, logic h, logic re, logic m, logic t);
    vec_t x;
    x.stall = s; x.redir = r; x.rpc = p; x.exc = e; x.halt = h; x.resume = re; x.sm = m; x.step = t;
    return x;
  endfunction

  function automatic row_t r(vec_t i, logic [31:0] p, logic [1:0] s, logic f, logic [31:0] c);
    row_t x;
    x.in = i; x.pc = p; x.st = s; x.fv = f; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic apply(input vec_t x);
    stall = x.stall; redir = x.redir; rpc = x.rpc; exc = x.exc;
    halt = x.halt; resume = x.resume; sm = x.sm; step = x.step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(v(0,0,0,0,0,0,0,0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // behavioural model: priority list applied to abstract state, one call per edge
  int          m_state, m_edges, m_cnt;
  logic        m_fv;
  logic [31:0] m_pc_a, m_pc_b;

  task automatic model_reset();
    m_state = 0; m_edges = 0; m_cnt = 0; m_fv = 0; m_pc_a = 32'h0; m_pc_b = 32'hFFFF_FFF8;
  endtask

  task automatic model_step(input vec_t x);
    bit awake = (m_state != 1);
    bit moved = 0, halted = 0;
    if (awake && x.exc) begin
      m_pc_a = 32'h80; m_pc_b = 32'h80; moved = 1;
    end else if (awake && x.redir) begin
      m_pc_a = x.rpc; m_pc_b = x.rpc; moved = 1;
    end else if (awake && x.halt) halted = 1;
    else if (x.stall) moved = 0;
    else if ((m_state == 0 && m_edges > 0) || (m_state == 2 && x.step)) begin
      m_pc_a = m_pc_a + 4; m_pc_b = m_pc_b + 4; moved = 1;
    end
    m_fv = halted ? 1'b0 : (m_state == 0) ? 1'b1 : (m_state == 2) ? moved : 1'b0;
    if (halted) m_state = 1;
    else if (m_state == 0 && x.sm) m_state = 2;
    else if (m_state == 2 && !x.sm) m_state = 0;
    else if (m_state == 1 && x.resume) m_state = x.sm ? 2 : 0;
    if (moved) m_cnt++;
    m_edges++;
  endtask

  initial begin
    tbl.push_back(r(v(0,0,0,0,0,0,0,0), 32'h00, 0, 1, 0));
    tbl.push_back(r(v(0,0,0,0,0,0,0,0), 32'h04, 0, 1, 1));
    tbl.push_back(r(v(0,0,0,0,0,0,0,0), 32'h08, 0, 1, 2));
    tbl.push_back(r(v(0,0,0,0,0,0,0,0), 32'h0C, 0, 1, 3));
    tbl.push_back(r(v(1,0,0,0,0,0,0,0), 32'h0C, 0, 1, 3));
    tbl.push_back(r(v(1,0,0,0,0,0,0,0), 32'h0C, 0, 1, 3));
    tbl.push_back(r(v(1,1,32'h40,0,0,0,0,0), 32'h40, 0, 1, 4));
    tbl.push_back(r(v(0,1,32'h42,1,1,0,0,0), 32'h80, 0, 1, 5));
    tbl.push_back(r(v(0,1,32'h42,0,0,0,0,0), 32'h42, 0, 1, 6));
    tbl.push_back(r(v(0,1,32'h0C,0,0,0,0,0), 32'h0C, 0, 1, 7));
    tbl.push_back(r(v(0,0,0,0,0,0,0,0), 32'h10, 0, 1, 8));
    tbl.push_back(r(v(0,0,0,0,1,0,0,0), 32'h10, 1, 0, 8));
    tbl.push_back(r(v(0,1,32'h99,0,0,0,0,0), 32'h10, 1, 0, 8));
    tbl.push_back(r(v(0,0,0,1,0,0,0,0), 32'h10, 1, 0, 8));
    tbl.push_back(r(v(0,0,0,0,0,0,0,1), 32'h10, 1, 0, 8));
    tbl.push_back(r(v(0,0,0,0,0,1,0,0), 32'h10, 0, 0, 8));
    tbl.push_back(r(v(0,0,0,0,0,0,0,0), 32'h14, 0, 1, 9));
    tbl.push_back(r(v(0,0,0,0,0,0,1,0), 32'h18, 2, 1, 10));
    tbl.push_back(r(v(0,0,0,0,0,0,1,0), 32'h18, 2, 0, 10));
    tbl.push_back(r(v(0,0,0,0,0,0,1,1), 32'h1C, 2, 1, 11));
    tbl.push_back(r(v(0,0,0,0,0,0,1,0), 32'h1C, 2, 0, 11));
    tbl.push_back(r(v(0,0,0,0,0,0,1,0), 32'h1C, 2, 0, 11));
    tbl.push_back(r(v(0,0,0,0,0,0,1,1), 32'h20, 2, 1, 12));
    tbl.push_back(r(v(0,0,0,0,0,0,1,0), 32'h20, 2, 0, 12));
    tbl.push_back(r(v(0,0,0,0,1,0,1,0), 32'h20, 1, 0, 12));
    tbl.push_back(r(v(0,0,0,0,0,1,1,0), 32'h20, 2, 0, 12));
    tbl.push_back(r(v(0,0,0,0,0,0,1,1), 32'h24, 2, 1, 13));
    tbl.push_back(r(v(0,0,0,0,0,0,0,0), 32'h24, 0, 0, 13));
    tbl.push_back(r(v(0,0,0,0,0,0,0,0), 32'h28, 0, 1, 14));

    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", pc_a, 32'h0);
    chk("reset state", 32'(st_a), 0);
    chk("reset fv", 32'(fv_a), 0);
    chk("reset cnt", cnt_a, 0);
    chk("reset pc_b", pc_b, 32'hFFFF_FFF8);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].in);
      chk($sformatf("tbl%0d pc", i), pc_a, tbl[i].pc);
      chk($sformatf("tbl%0d state", i), 32'(st_a), 32'(tbl[i].st));
      chk($sformatf("tbl%0d fv", i), 32'(fv_a), 32'(tbl[i].fv));
      chk($sformatf("tbl%0d cnt", i), cnt_a, tbl[i].cnt);
      chk($sformatf("tbl%0d nxt", i), nxt_a, tbl[i].pc + 32'd4);
      chk($sformatf("tbl%0d mis", i), 32'(mis_a), 32'(tbl[i].pc[1:0] != 2'b00));
    end

    do_reset();
    for (int i = 1; i <= 6; i++) begin
      apply(v(0,0,0,0,0,0,0,0));
      if (i == 3) chk("wrap pc_b", pc_b, 32'h0);
    end
    chk("sat pc_b", pc_b, 32'h0C);
    chk("sat cnt_b", 32'(cnt_b), 3);

    do_reset();
    apply(v(0,0,0,0,0,0,0,0));
    apply(v(0,0,0,0,0,0,1,0));
    apply(v(0,0,0,0,0,0,1,1));
    chk("pre-areset state", 32'(st_a), 2);
    chk("pre-areset pc", pc_a, 32'h08);
    #2 rst = 1'b1;
    #1;
    chk("areset pc", pc_a, 32'h0);
    chk("areset state", 32'(st_a), 0);
    chk("areset fv", 32'(fv_a), 0);
    chk("areset cnt", cnt_a, 0);
    chk("areset pc_b", pc_b, 32'hFFFF_FFF8);
    chk("areset cnt_b", 32'(cnt_b), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_reset();
    model_reset();
    begin
      bit sm_r = 0;
      for (int i = 0; i < 500; i++) begin
        vec_t x;
        if ($urandom_range(15) == 0) sm_r = ~sm_r;
        x = v($urandom_range(4) == 0, $urandom_range(7) == 0,
              ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
              $urandom_range(15) == 0, $urandom_range(9) == 0, $urandom_range(3) == 0,
              sm_r, $urandom_range(2) == 0);
        apply(x);
        model_step(x);
        chk($sformatf("rnd%0d pc", i), pc_a, m_pc_a);
        chk($sformatf("rnd%0d pc_b", i), pc_b, m_pc_b);
        chk($sformatf("rnd%0d state", i), 32'(st_a), 32'(m_state));
        chk($sformatf("rnd%0d fv", i), 32'(fv_a), 32'(m_fv));
        chk($sformatf("rnd%0d cnt", i), cnt_a, 32'(m_cnt));
        chk($sformatf("rnd%0d cnt_b", i), 32'(cnt_b), (m_cnt > 3) ? 3 : m_cnt);
        chk($sformatf("rnd%0d nxt", i), nxt_a, m_pc_a + 32'd4);
        chk($sformatf("rnd%0d mis", i), 32'(mis_a), 32'(m_pc_a[1:0] != 2'b00));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
